// File: rtl/pipeline_hazard_controller.sv
// Hazard controller for a five-stage in-order pipeline.
// Generates stall/flush controls for memory waits, taken branches and load-use
// hazards, drives the Execute-stage forwarding muxes, flags memory-wait
// timeouts and keeps stall/flush performance counters.
module pipeline_hazard_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_d,
    input  logic [4:0]  rs2_d,
    input  logic [4:0]  rs1_e,
    input  logic [4:0]  rs2_e,
    input  logic [4:0]  rd_e,
    input  logic        mem_read_e,
    input  logic        pc_src_e,
    input  logic [4:0]  rd_m,
    input  logic [4:0]  rd_w,
    input  logic        reg_write_m,
    input  logic        reg_write_w,
    input  logic        mem_req_m,
    input  logic        mem_ready,
    output logic        stall_f,
    output logic        stall_d,
    output logic        stall_e,
    output logic        stall_m,
    output logic        flush_d,
    output logic        flush_e,
    output logic        flush_w,
    output logic [1:0]  forward_a_e,
    output logic [1:0]  forward_b_e,
    output logic        mem_timeout,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t     state;
    logic [7:0] wait_cnt;
    logic       freeze;
    logic       load_use;

    // Freeze whenever the Memory stage is waiting on data memory; a ready
    // response releases the pipeline in the very same cycle.
    always_comb begin
        freeze = 1'b0;
        if (state == RUN) begin
            freeze = mem_req_m && !mem_ready;
        end else begin
            freeze = !mem_ready;
        end
        load_use = mem_read_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    end

    // Prioritised stall/flush generation: memory freeze, then redirect, then load-use.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (!rst) begin
            if (freeze) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (pc_src_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (load_use) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    // Operand forwarding into Execute; the younger Memory-stage result wins.
    always_comb begin
        forward_a_e = 2'b00;
        forward_b_e = 2'b00;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs1_e)) begin
            forward_a_e = 2'b10;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs1_e)) begin
            forward_a_e = 2'b01;
        end
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs2_e)) begin
            forward_b_e = 2'b10;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs2_e)) begin
            forward_b_e = 2'b01;
        end
    end

    // Memory-wait FSM with a 256-cycle watchdog and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= 8'd0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_req_m && !mem_ready) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 8'd0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state <= RUN;
                    end else if (wait_cnt == 8'hFF) begin
                        state       <= RUN;
                        mem_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // Free-running performance counters; a cycle flushing both D and E counts once.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= 32'd0;
            flush_count <= 32'd0;
        end else begin
            if (stall_f) begin
                stall_count <= stall_count + 32'd1;
            end
            if (flush_d || flush_e) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed testbench for pipeline_hazard_controller: a table of single-cycle
// vectors run from the RUN state, followed by hand-written multi-cycle
// sequences for memory waits, the watchdog timeout and reset mid-wait.
module tb_pipeline_hazard_controller;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic        mem_read_e, pc_src_e, reg_write_m, reg_write_w, mem_req_m, mem_ready;
    logic        stall_f, stall_d, stall_e, stall_m;
    logic        flush_d, flush_e, flush_w;
    logic [1:0]  forward_a_e, forward_b_e;
    logic        mem_timeout;
    logic [31:0] stall_count, flush_count;

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       mr, pc, wm, ww, rq, rdy;
        logic [3:0] st;
        logic [2:0] fl;
        logic [1:0] fa, fb;
    } vec_t;

    vec_t        vecs[12];
    int          vecCount  = 0;
    int          missCount = 0;
    int unsigned expStall  = 0;
    int unsigned expFlush  = 0;

    pipeline_hazard_controller dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .mem_read_e(mem_read_e), .pc_src_e(pc_src_e),
        .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .mem_req_m(mem_req_m), .mem_ready(mem_ready),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .mem_timeout(mem_timeout), .stall_count(stall_count), .flush_count(flush_count)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde,
                                   input logic mr, pc,
                                   input logic [4:0] rdm, rdw,
                                   input logic wm, ww, rq, rdy,
                                   input logic [3:0] st, input logic [2:0] fl,
                                   input logic [1:0] fa, fb);
        vec_t v;
        v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e; v.rde = rde;
        v.mr = mr; v.pc = pc; v.rdm = rdm; v.rdw = rdw; v.wm = wm; v.ww = ww;
        v.rq = rq; v.rdy = rdy; v.st = st; v.fl = fl; v.fa = fa; v.fb = fb;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rs1_d = v.rs1d; rs2_d = v.rs2d; rs1_e = v.rs1e; rs2_e = v.rs2e; rd_e = v.rde;
        mem_read_e = v.mr; pc_src_e = v.pc; rd_m = v.rdm; rd_w = v.rdw;
        reg_write_m = v.wm; reg_write_w = v.ww; mem_req_m = v.rq; mem_ready = v.rdy;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] stallVec();
        return {28'd0, stall_f, stall_d, stall_e, stall_m};
    endfunction

    function automatic logic [31:0] flushVec();
        return {29'd0, flush_d, flush_e, flush_w};
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Table: every vector is applied from RUN with no pending memory wait.
        //                 rs1d  rs2d  rs1e  rs2e  rde  mr  pc  rdm   rdw  wm  ww  rq  rdy   st       fl      fa     fb
        vecs[0]  = mkVec(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 4'b0000, 3'b000, 2'b00, 2'b00);
        vecs[1]  = mkVec(5'd5, 5'd1, 5'd0, 5'd0, 5'd5, 1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 4'b1100, 3'b010, 2'b00, 2'b00);
        vecs[2]  = mkVec(5'd2, 5'd9, 5'd0, 5'd0, 5'd9, 1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 4'b1100, 3'b010, 2'b00, 2'b00);
        vecs[3]  = mkVec(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 4'b0000, 3'b000, 2'b00, 2'b00);
        vecs[4]  = mkVec(5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 4'b0000, 3'b000, 2'b00, 2'b00);
        vecs[5]  = mkVec(5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 1, 1, 5'd0, 5'd0, 0, 0, 0, 0, 4'b0000, 3'b110, 2'b00, 2'b00);
        vecs[6]  = mkVec(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 1, 5'd0, 5'd0, 0, 0, 0, 0, 4'b0000, 3'b110, 2'b00, 2'b00);
        vecs[7]  = mkVec(5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 0, 0, 5'd7, 5'd7, 1, 1, 0, 0, 4'b0000, 3'b000, 2'b10, 2'b00);
        vecs[8]  = mkVec(5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 0, 0, 5'd7, 5'd7, 0, 1, 0, 0, 4'b0000, 3'b000, 2'b01, 2'b00);
        vecs[9]  = mkVec(5'd0, 5'd0, 5'd4, 5'd3, 5'd0, 0, 0, 5'd3, 5'd4, 1, 1, 0, 0, 4'b0000, 3'b000, 2'b01, 2'b10);
        vecs[10] = mkVec(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 1, 1, 0, 0, 4'b0000, 3'b000, 2'b00, 2'b00);
        vecs[11] = mkVec(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 0, 1, 1, 4'b0000, 3'b000, 2'b00, 2'b00);

        // Reset with every hazard input active: controls must stay quiet.
        rst = 1'b1;
        applyStimulus(mkVec(5'd5, 5'd5, 5'd0, 5'd0, 5'd5, 1, 1, 5'd0, 5'd0, 0, 0, 1, 0, 4'b0, 3'b0, 2'b0, 2'b0));
        @(negedge clk);
        checkOutput("reset_stall", stallVec(), 32'h0);
        checkOutput("reset_flush", flushVec(), 32'h0);
        nextCycle();
        nextCycle();
        checkOutput("reset_stall_count", stall_count, 32'd0);
        checkOutput("reset_flush_count", flush_count, 32'd0);
        checkOutput("reset_timeout", {31'd0, mem_timeout}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_stall", i), stallVec(), {28'd0, vecs[i].st});
            checkOutput($sformatf("vec%0d_flush", i), flushVec(), {29'd0, vecs[i].fl});
            checkOutput($sformatf("vec%0d_fwd_a", i), {30'd0, forward_a_e}, {30'd0, vecs[i].fa});
            checkOutput($sformatf("vec%0d_fwd_b", i), {30'd0, forward_b_e}, {30'd0, vecs[i].fb});
            if (vecs[i].st[3]) expStall++;
            if (vecs[i].fl[2] || vecs[i].fl[1]) expFlush++;
            nextCycle();
            checkOutput($sformatf("vec%0d_stall_count", i), stall_count, expStall);
            checkOutput($sformatf("vec%0d_flush_count", i), flush_count, expFlush);
        end

        // Memory wait for three cycles, with a redirect and load-use hidden under the freeze.
        for (int c = 0; c < 3; c++) begin
            applyStimulus(mkVec(5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 1, (c == 1), 5'd0, 5'd0, 0, 0, 1, 0, 4'b0, 3'b0, 2'b0, 2'b0));
            @(negedge clk);
            checkOutput($sformatf("memwait%0d_stall", c), stallVec(), 32'hF);
            checkOutput($sformatf("memwait%0d_flush", c), flushVec(), 32'h1);
            expStall++;
            nextCycle();
        end
        applyStimulus(mkVec(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 0, 1, 1, 4'b0, 3'b0, 2'b0, 2'b0));
        @(negedge clk);
        checkOutput("memready_stall", stallVec(), 32'h0);
        checkOutput("memready_flush", flushVec(), 32'h0);
        nextCycle();
        checkOutput("memwait_stall_count", stall_count, expStall);
        checkOutput("memwait_flush_count", flush_count, expFlush);
        mem_req_m = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        checkOutput("after_memwait_run", stallVec(), 32'h0);
        nextCycle();

        // Reset mid-wait aborts the wait and clears all state.
        mem_req_m = 1'b1;
        nextCycle();
        mem_req_m = 1'b0;
        nextCycle();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_midwait_stall", stallVec(), 32'h0);
        checkOutput("rst_midwait_flush", flushVec(), 32'h0);
        nextCycle();
        rst = 1'b0;
        expStall = 0;
        expFlush = 0;
        @(negedge clk);
        checkOutput("post_rst_stall", stallVec(), 32'h0);
        checkOutput("post_rst_flush", flushVec(), 32'h0);
        checkOutput("post_rst_stall_count", stall_count, 32'd0);
        checkOutput("post_rst_flush_count", flush_count, 32'd0);
        checkOutput("post_rst_timeout", {31'd0, mem_timeout}, 32'd0);
        nextCycle();

        // Watchdog: one entry cycle plus 256 waiting cycles, then forced back to RUN.
        mem_req_m = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        checkOutput("timeout_entry_stall", stallVec(), 32'hF);
        expStall++;
        nextCycle();
        mem_req_m = 1'b0;
        for (int c = 0; c < 256; c++) begin
            @(negedge clk);
            checkOutput($sformatf("timeout_wait%0d_stall", c), stallVec(), 32'hF);
            expStall++;
            if (c == 255) checkOutput("timeout_not_yet", {31'd0, mem_timeout}, 32'd0);
            nextCycle();
        end
        @(negedge clk);
        checkOutput("timeout_released", stallVec(), 32'h0);
        checkOutput("timeout_flag", {31'd0, mem_timeout}, 32'd1);
        checkOutput("timeout_stall_count", stall_count, expStall);
        for (int c = 0; c < 4; c++) nextCycle();
        checkOutput("timeout_sticky", {31'd0, mem_timeout}, 32'd1);
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("timeout_cleared", {31'd0, mem_timeout}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
